timer_reg_mch: RTL and testbench
================================

// Module: timer_reg_mch
// PURPOSE
//  Next-generation timer register file and counter core: APB-mapped control/status registers,
//  an internal prescaler, a CNT_W-bit up-counter and NUM_CH independent compare channels.
//  Each channel has its own interrupt enable and W1C status bit. Sits behind the APB slave FSM.
//  Drives the combined tim_int line and the debug-halt handshake.
// PARAMETERS
//  CNT_W   64  counter/compare width; legal values 32 or 64. High words read 0 when 32.
//  NUM_CH  4   number of compare channels, 1..8.
//  ADDR_W  12  APB address width.
// PORTS
//  sys_clk     in   1          single clock; everything is posedge.
//  sys_rst     in   1          synchronous, active-high reset.
//  wr_en       in   1          qualified APB write (access phase) from the slave FSM.
//  rd_en       in   1          qualified APB read.
//  pready      in   1          APB ready; rdata is valid only when rd_en&pready.
//  tim_paddr   in   ADDR_W     byte address; word aligned.
//  tim_pwdata  in   32         write data.
//  tim_pstrb   in   4          byte strobes; byte k is written only when pstrb[k]=1.
//  dbg_mode    in   1          CPU debug state.
//  rdata       out  32         read data; 0 when not (rd_en&pready) or the address is unmapped.
//  pslverr     out  1          combinational error for the current access.
//  halt_ack    out  1          = halt_req & dbg_mode, registered.
//  tim_int     out  1          = |(int_st & int_en), registered.
// BEHAVIOUR
//  Register map:
//   0x00 TCR: [0] timer_en, [1] div_en, [2] one_shot (macro only), [11:8] div_val.
//   0x04 TDR0 = cnt[31:0]; 0x08 TDR1 = cnt[63:32].
//   0x0C TIER int_en[NUM_CH-1:0]; 0x10 TISR int_st W1C; 0x14 THCSR {halt_ack, halt_req}.
//   0x100+8*n TCMPn_LO; 0x104+8*n TCMPn_HI.
//  Reset values: timer_en=0, div_en=0, div_val=1, cnt=0, all tcmp=all-ones, int_en=0, int_st=0,
//   halt_req=0, halt_ack=0, tim_int=0, prescaler=0.
//  pslverr is asserted for a TCR write when any of the following holds:
//   - pstrb[1] and pwdata[11:8]>8;
//   - timer_en=1 and pstrb[1] and pwdata[11:8]!=div_val;
//   - timer_en=1 and pstrb[0] and pwdata[1]!=div_en.
//  On pslverr the whole TCR write is dropped. No other access errors.
//  Prescaler: runs when timer_en & !halt_ack.
//   - div_en=0: tick every cycle.
//   - div_en=1: tick when pcnt==(1<<div_val)-1, then pcnt<=0; div_val=0 gives a tick every cycle.
//  Counter: cnt<=cnt+1 on tick; wraps from all-ones to 0.
//   - A TDR0/TDR1 write loads the strobed bytes and suppresses the increment for that cycle.
//   - Write wins over count.
//  timer_en 1->0: cnt and pcnt clear on the next cycle; the register write in that cycle has priority.
//  Compare: match[n] = (cnt==tcmp[n]) over the full CNT_W, evaluated every cycle (level).
//   - match[n] sets int_st[n] next cycle.
//   - W1C clear with pstrb[0] and pwdata[n]=1 wins over a same-cycle set.
//  Halt: halt_ack=1 freezes the prescaler and counter; registers stay accessible.
//  Latency: a register write is visible on the next-cycle read; tim_int follows int_st by 1 cycle.
//  Mid-operation reset: every state returns to its reset value on the next edge.
// CONFIGURATION
//  TIMER_ONESHOT_EN defined:
//   - TCR[2] is writable, reset 0.
//   - When one_shot=1 and match[0] rises, timer_en clears on the next edge; the counter then clears per the disable rule.
//   - int_st[0] sets as normal.
//  TIMER_ONESHOT_EN undefined: TCR[2] reads 0 and writes to it are ignored; free-running only.
// STRUCTURE
//  timer_pkg: address offsets, TCR bit positions, DIV_MAX=8, CH_BASE=0x100, CH_STRIDE=8.
//  Sub-module timer_prescaler (timer_en, div_en, div_val, halt -> tick).
//  Channels are built with a generate loop.
// TESTING
//  - Reset, then read all registers -> TCR=0x100, TCMPn=0xFFFF_FFFF, all others 0.
//  - div_en=1, div_val=2, timer_en=1 -> TDR0 increments once every 4 cycles; TCR write with div_val=3 -> pslverr=1, TCR unchanged.
//  - Write TDR0=0xFFFF_FFFE, TDR1=0 and run with div_en=0 -> TDR1=1 and TDR0=0 after 2 ticks.
//  - TCMP2=0x10, TIER=0x4 -> int_st[2] and tim_int=1 one cycle after cnt==0x10; W1C in the same cycle as a match -> stays 0.
//  - THCSR=1 with dbg_mode=1 -> halt_ack=1 and cnt frozen; dbg_mode=0 -> counting resumes.
//  - With TIMER_ONESHOT_EN, one_shot=1, TCMP0=5 -> timer_en=0 after the match, cnt=0, int_st[0]=1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register offsets, TCR field positions and helpers for the timer core.
package timer_pkg;

    localparam int TCR_OFF   = 'h000;
    localparam int TDR0_OFF  = 'h004;
    localparam int TDR1_OFF  = 'h008;
    localparam int TIER_OFF  = 'h00C;
    localparam int TISR_OFF  = 'h010;
    localparam int THCSR_OFF = 'h014;
    localparam int CH_BASE   = 'h100;
    localparam int CH_STRIDE = 8;

    localparam int DIV_MAX = 8;
    localparam int PCNT_W  = DIV_MAX;

    localparam int TCR_EN_BIT    = 0;
    localparam int TCR_DIVEN_BIT = 1;
    localparam int TCR_OS_BIT    = 2;
    localparam int TCR_DIVV_LSB  = 8;

    localparam logic [3:0] DIV_VAL_RST = 4'd1;

    typedef enum logic [2:0] {
        REG_TCR,
        REG_TDR0,
        REG_TDR1,
        REG_TIER,
        REG_TISR,
        REG_THCSR,
        REG_TCMP,
        REG_NONE
    } reg_sel_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every 2^div_val cycles (or every cycle when
// division is off) while the timer is enabled and not halted.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       div_en_i,
    input  logic [3:0] div_val_i,
    input  logic       halt_i,
    output logic       tick_o
);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [PCNT_W-1:0] lim;
    logic              run;
    logic              last;

    // div_val is bounded to DIV_MAX by the register file, so the limit always fits.
    assign lim    = PCNT_W'((32'd1 << div_val_i) - 32'd1);
    assign run    = en_i && !halt_i;
    assign last   = !div_en_i || (pcnt_q == lim);
    assign tick_o = run && last;

    always_comb begin
        pcnt_d = pcnt_q;
        if (!en_i) begin
            pcnt_d = '0;
        end else if (run) begin
            pcnt_d = last ? '0 : pcnt_q + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/timer_reg_mch.sv
// Timer register file and counter core: APB control/status, prescaled up-counter and
// NUM_CH compare channels. Define TIMER_ONESHOT_EN to enable the one-shot mode (TCR[2]).
module timer_reg_mch
    import timer_pkg::*;
#(
    parameter int CNT_W  = 64,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              pready,
    input  logic [ADDR_W-1:0] tim_paddr,
    input  logic [31:0]       tim_pwdata,
    input  logic [3:0]        tim_pstrb,
    input  logic              dbg_mode,
    output logic [31:0]       rdata,
    output logic              pslverr,
    output logic              halt_ack,
    output logic              tim_int
);

    reg_sel_e          sel;
    logic [2:0]        ch_idx;
    logic              ch_hi;
    logic              tcr_wr, tcr_err, tdr0_wr, tdr1_wr, tier_wr, tisr_wr, thcsr_wr;

    logic              timer_en_q, timer_en_d;
    logic              div_en_q, div_en_d;
    logic [3:0]        div_val_q, div_val_d;
    logic              one_shot;
    logic              en_prev_q;
    logic              en_fall;
    logic              tick;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       cnt_ext, cnt_wr;

    logic [NUM_CH-1:0] int_en_q, int_en_d;
    logic [NUM_CH-1:0] int_st_q, int_st_d;
    logic [NUM_CH-1:0] match;
    logic              halt_req_q, halt_req_d;
    logic              halt_ack_q;
    logic              tim_int_q;

    logic [31:0]       tcmp_lo_rd [NUM_CH];
    logic [31:0]       tcmp_hi_rd [NUM_CH];
    logic [31:0]       rd_word;

    always_comb begin
        sel    = REG_NONE;
        ch_idx = '0;
        ch_hi  = 1'b0;
        if (tim_paddr == ADDR_W'(TCR_OFF)) begin
            sel = REG_TCR;
        end else if (tim_paddr == ADDR_W'(TDR0_OFF)) begin
            sel = REG_TDR0;
        end else if (tim_paddr == ADDR_W'(TDR1_OFF)) begin
            sel = REG_TDR1;
        end else if (tim_paddr == ADDR_W'(TIER_OFF)) begin
            sel = REG_TIER;
        end else if (tim_paddr == ADDR_W'(TISR_OFF)) begin
            sel = REG_TISR;
        end else if (tim_paddr == ADDR_W'(THCSR_OFF)) begin
            sel = REG_THCSR;
        end else if ((tim_paddr >= ADDR_W'(CH_BASE)) &&
                     (tim_paddr <  ADDR_W'(CH_BASE + CH_STRIDE * NUM_CH))) begin
            sel    = REG_TCMP;
            ch_idx = 3'((tim_paddr - ADDR_W'(CH_BASE)) >> 3);
            ch_hi  = tim_paddr[2];
        end
    end

    assign tcr_wr   = wr_en && (sel == REG_TCR);
    assign tdr0_wr  = wr_en && (sel == REG_TDR0);
    assign tdr1_wr  = wr_en && (sel == REG_TDR1);
    assign tier_wr  = wr_en && (sel == REG_TIER);
    assign tisr_wr  = wr_en && (sel == REG_TISR);
    assign thcsr_wr = wr_en && (sel == REG_THCSR);

    // The divider settings are locked while the timer runs; a rejected TCR write is dropped whole.
    assign tcr_err = tcr_wr &&
        ((tim_pstrb[1] && (tim_pwdata[11:8] > 4'(DIV_MAX))) ||
         (timer_en_q && tim_pstrb[1] && (tim_pwdata[11:8] != div_val_q)) ||
         (timer_en_q && tim_pstrb[0] && (tim_pwdata[TCR_DIVEN_BIT] != div_en_q)));
    assign pslverr = tcr_err;

`ifdef TIMER_ONESHOT_EN
    logic one_shot_q, one_shot_d;
    logic match0_q;
    assign one_shot = one_shot_q;
`else
    assign one_shot = 1'b0;
`endif

    always_comb begin
        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        div_val_d  = div_val_q;
        int_en_d   = int_en_q;
        halt_req_d = halt_req_q;
`ifdef TIMER_ONESHOT_EN
        one_shot_d = one_shot_q;
        if (one_shot_q && match[0] && !match0_q) begin
            timer_en_d = 1'b0;
        end
`endif
        if (tcr_wr && !tcr_err) begin
            if (tim_pstrb[0]) begin
                timer_en_d = tim_pwdata[TCR_EN_BIT];
                div_en_d   = tim_pwdata[TCR_DIVEN_BIT];
`ifdef TIMER_ONESHOT_EN
                one_shot_d = tim_pwdata[TCR_OS_BIT];
`endif
            end
            if (tim_pstrb[1]) begin
                div_val_d = tim_pwdata[TCR_DIVV_LSB +: 4];
            end
        end
        if (tier_wr && tim_pstrb[0]) begin
            int_en_d = tim_pwdata[NUM_CH-1:0];
        end
        if (thcsr_wr && tim_pstrb[0]) begin
            halt_req_d = tim_pwdata[0];
        end
        // Clear-on-write beats a compare hit landing in the same cycle.
        int_st_d = int_st_q | match;
        if (tisr_wr && tim_pstrb[0]) begin
            int_st_d = int_st_d & ~tim_pwdata[NUM_CH-1:0];
        end
    end

    assign en_fall = en_prev_q && !timer_en_q;
    assign cnt_ext = 64'(cnt_q);

    always_comb begin
        cnt_wr = cnt_ext;
        if (tdr0_wr) begin
            cnt_wr[31:0] = strb_merge(cnt_ext[31:0], tim_pwdata, tim_pstrb);
        end
        if (tdr1_wr) begin
            cnt_wr[63:32] = strb_merge(cnt_ext[63:32], tim_pwdata, tim_pstrb);
        end
        cnt_d = cnt_q;
        if (tdr0_wr || tdr1_wr) begin
            cnt_d = cnt_wr[CNT_W-1:0];
        end else if (en_fall) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    timer_prescaler u_prescaler (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .en_i      (timer_en_q),
        .div_en_i  (div_en_q),
        .div_val_i (div_val_q),
        .halt_i    (halt_ack_q),
        .tick_o    (tick)
    );

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_W-1:0] tcmp_q, tcmp_d;
        logic [63:0]      tcmp_ext, tcmp_wr;
        logic             ch_sel;

        assign ch_sel   = wr_en && (sel == REG_TCMP) && (ch_idx == 3'(n));
        assign tcmp_ext = 64'(tcmp_q);

        always_comb begin
            tcmp_wr = tcmp_ext;
            if (ch_sel && !ch_hi) begin
                tcmp_wr[31:0] = strb_merge(tcmp_ext[31:0], tim_pwdata, tim_pstrb);
            end
            if (ch_sel && ch_hi) begin
                tcmp_wr[63:32] = strb_merge(tcmp_ext[63:32], tim_pwdata, tim_pstrb);
            end
            tcmp_d = tcmp_wr[CNT_W-1:0];
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                tcmp_q <= '1;
            end else begin
                tcmp_q <= tcmp_d;
            end
        end

        assign match[n]      = (cnt_q == tcmp_q);
        assign tcmp_lo_rd[n] = tcmp_ext[31:0];
        assign tcmp_hi_rd[n] = tcmp_ext[63:32];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= DIV_VAL_RST;
            en_prev_q  <= 1'b0;
            cnt_q      <= '0;
            int_en_q   <= '0;
            int_st_q   <= '0;
            halt_req_q <= 1'b0;
            halt_ack_q <= 1'b0;
            tim_int_q  <= 1'b0;
        end else begin
            timer_en_q <= timer_en_d;
            div_en_q   <= div_en_d;
            div_val_q  <= div_val_d;
            en_prev_q  <= timer_en_q;
            cnt_q      <= cnt_d;
            int_en_q   <= int_en_d;
            int_st_q   <= int_st_d;
            halt_req_q <= halt_req_d;
            halt_ack_q <= halt_req_q && dbg_mode;
            tim_int_q  <= |(int_st_q & int_en_q);
        end
    end

`ifdef TIMER_ONESHOT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            one_shot_q <= 1'b0;
            match0_q   <= 1'b0;
        end else begin
            one_shot_q <= one_shot_d;
            match0_q   <= match[0];
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (sel)
            REG_TCR:   rd_word = {20'd0, div_val_q, 5'd0, one_shot, div_en_q, timer_en_q};
            REG_TDR0:  rd_word = cnt_ext[31:0];
            REG_TDR1:  rd_word = cnt_ext[63:32];
            REG_TIER:  rd_word = 32'(int_en_q);
            REG_TISR:  rd_word = 32'(int_st_q);
            REG_THCSR: rd_word = {30'd0, halt_ack_q, halt_req_q};
            REG_TCMP: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_idx == 3'(n)) begin
                        rd_word = ch_hi ? tcmp_hi_rd[n] : tcmp_lo_rd[n];
                    end
                end
            end
            default:   rd_word = '0;
        endcase
    end

    assign rdata    = (rd_en && pready) ? rd_word : '0;
    assign halt_ack = halt_ack_q;
    assign tim_int  = tim_int_q;

endmodule

// File: tb/tb_timer_reg_mch.sv
// Scoreboarded bench for timer_reg_mch: read expectations are queued when a read is issued
// and compared when the read data is sampled.
module tb_timer_reg_mch;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wr_en, rd_en, pready;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic        dbg_mode;
    logic [31:0] rdata;
    logic        pslverr, halt_ack, tim_int;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] sb_exp;
    string       sb_tag;

    timer_reg_mch #(.CNT_W(64), .NUM_CH(4), .ADDR_W(12)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .pready     (pready),
        .tim_paddr  (tim_paddr),
        .tim_pwdata (tim_pwdata),
        .tim_pstrb  (tim_pstrb),
        .dbg_mode   (dbg_mode),
        .rdata      (rdata),
        .pslverr    (pslverr),
        .halt_ack   (halt_ack),
        .tim_int    (tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Read data is sampled on the falling edge of each read cycle.
    always @(negedge sys_clk) begin
        if (rd_en && pready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_read", 1, 0);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_tag = tag_q.pop_front();
                chk(sb_tag, rdata, sb_exp);
            end
        end
    end

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
        @(posedge sys_clk); #1;
        wr_en = 1'b0; tim_pstrb = 4'h0;
    endtask

    task automatic wr_err(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_err, input string tag);
        wr_en = 1'b1; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
        @(negedge sys_clk);
        chk(tag, pslverr, exp_err);
        @(posedge sys_clk); #1;
        wr_en = 1'b0; tim_pstrb = 4'h0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_en = 1'b1; tim_paddr = a;
        @(posedge sys_clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        sys_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; pready = 1'b1;
        tim_paddr = '0; tim_pwdata = '0; tim_pstrb = '0; dbg_mode = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Reset state of every register
        chk("rst_tim_int", tim_int, 0);
        chk("rst_halt_ack", halt_ack, 0);
        rd(12'h000, 32'h0000_0100, "rst_tcr");
        rd(12'h004, 32'h0, "rst_tdr0");
        rd(12'h008, 32'h0, "rst_tdr1");
        rd(12'h00C, 32'h0, "rst_tier");
        rd(12'h010, 32'h0, "rst_tisr");
        rd(12'h014, 32'h0, "rst_thcsr");
        for (int n = 0; n < 4; n++) begin
            rd(12'h100 + 12'(8 * n), 32'hFFFF_FFFF, $sformatf("rst_tcmp%0d_lo", n));
            rd(12'h104 + 12'(8 * n), 32'hFFFF_FFFF, $sformatf("rst_tcmp%0d_hi", n));
        end
        rd(12'h018, 32'h0, "unmapped_018");
        rd(12'h120, 32'h0, "unmapped_ch4");
        rd_en = 1'b1; pready = 1'b0; tim_paddr = 12'h000;
        @(negedge sys_clk);
        chk("rdata_no_ready", rdata, 0);
        @(posedge sys_clk); #1;
        rd_en = 1'b0; pready = 1'b1;

        // Prescaler: divide by 4
        wr_err(12'h000, 32'h0000_0203, 4'h3, 1'b0, "tcr_enable_ok");
        idle(3);
        rd(12'h004, 32'd0, "div4_before_tick");
        rd(12'h004, 32'd1, "div4_tick1");
        idle(2);
        rd(12'h004, 32'd1, "div4_hold");
        rd(12'h004, 32'd2, "div4_tick2");
        wr_err(12'h000, 32'h0000_0303, 4'h3, 1'b1, "err_divval_running");
        rd(12'h000, 32'h0000_0203, "tcr_kept_divval");
        wr_err(12'h000, 32'h0000_0201, 4'h1, 1'b1, "err_diven_running");
        rd(12'h000, 32'h0000_0203, "tcr_kept_diven");
        wr_err(12'h000, 32'h0000_0202, 4'h1, 1'b0, "tcr_disable_ok");
        idle(2);
        rd(12'h004, 32'd0, "disable_clears_cnt");
        rd(12'h000, 32'h0000_0202, "tcr_disabled");
        wr_err(12'h000, 32'h0000_0900, 4'h2, 1'b1, "err_divval_gt8");
        rd(12'h000, 32'h0000_0202, "tcr_kept_gt8");
        wr_err(12'h000, 32'h0000_0800, 4'h2, 1'b0, "divval8_ok");
        rd(12'h000, 32'h0000_0802, "tcr_divval8");

        // Counter load with byte strobes, then 32-bit carry
        wr(12'h004, 32'hAABB_CCDD, 4'b0101);
        rd(12'h004, 32'h00BB_00DD, "tdr0_strobed");
        wr(12'h004, 32'hFFFF_FFFE, 4'hF);
        wr(12'h008, 32'h0, 4'hF);
        rd(12'h004, 32'hFFFF_FFFE, "tdr0_loaded");
        wr_err(12'h000, 32'h0000_0001, 4'h1, 1'b0, "tcr_run_nodiv");
        rd(12'h004, 32'hFFFF_FFFE, "carry_t0");
        rd(12'h004, 32'hFFFF_FFFF, "carry_t1");
        rd(12'h004, 32'h0000_0000, "carry_lo_wrap");
        rd(12'h008, 32'h0000_0001, "carry_hi");
        wr(12'h000, 32'h0, 4'h1);
        idle(2);
        rd(12'h008, 32'h0, "tdr1_cleared");

        // Compare channel 2 and interrupt
        wr(12'h110, 32'h10, 4'hF);
        wr(12'h114, 32'h0, 4'hF);
        wr(12'h00C, 32'h4, 4'h1);
        rd(12'h110, 32'h10, "tcmp2_lo");
        rd(12'h114, 32'h0, "tcmp2_hi");
        rd(12'h00C, 32'h4, "tier");
        wr(12'h000, 32'h1, 4'h1);
        idle(16);
        rd(12'h010, 32'h0, "tisr_before_match");
        chk("tim_int_before", tim_int, 0);
        rd(12'h010, 32'h4, "tisr_after_match");
        chk("tim_int_after", tim_int, 1);
        wr(12'h000, 32'h0, 4'h1);
        wr(12'h010, 32'h4, 4'h1);
        rd(12'h010, 32'h0, "tisr_w1c");
        wr(12'h110, 32'h0, 4'hF);
        wr(12'h010, 32'h4, 4'h1);
        rd(12'h010, 32'h0, "w1c_beats_match");
        rd(12'h010, 32'h4, "match_sets_again");
        wr(12'h110, 32'hFFFF_FFFF, 4'hF);
        wr(12'h010, 32'h4, 4'h1);
        rd(12'h010, 32'h0, "tisr_idle_clear");
        idle(2);
        chk("tim_int_dropped", tim_int, 0);

        // Debug halt
        dbg_mode = 1'b1;
        wr(12'h000, 32'h1, 4'h1);
        wr(12'h014, 32'h1, 4'h1);
        idle(2);
        chk("halt_ack_set", halt_ack, 1);
        rd(12'h004, 32'd2, "halted_cnt");
        idle(5);
        rd(12'h004, 32'd2, "halted_frozen");
        rd(12'h014, 32'h3, "thcsr_halted");
        dbg_mode = 1'b0;
        rd(12'h004, 32'd2, "resume_c0");
        rd(12'h004, 32'd2, "resume_c1");
        rd(12'h004, 32'd3, "resume_c2");
        rd(12'h004, 32'd4, "resume_c3");
        chk("halt_ack_clear", halt_ack, 0);

        // Reset while running
        sys_rst = 1'b1;
        idle(1);
        sys_rst = 1'b0;
        rd(12'h000, 32'h0000_0100, "mid_rst_tcr");
        rd(12'h004, 32'h0, "mid_rst_tdr0");
        rd(12'h014, 32'h0, "mid_rst_thcsr");
        rd(12'h110, 32'hFFFF_FFFF, "mid_rst_tcmp2");
        rd(12'h00C, 32'h0, "mid_rst_tier");
        chk("mid_rst_halt_ack", halt_ack, 0);
        chk("mid_rst_tim_int", tim_int, 0);

        // One-shot bit and channel 0 match
        wr(12'h000, 32'h4, 4'h1);
`ifdef TIMER_ONESHOT_EN
        rd(12'h000, 32'h0000_0104, "tcr_oneshot_bit");
`else
        rd(12'h000, 32'h0000_0100, "tcr_oneshot_ignored");
`endif
        wr(12'h100, 32'h5, 4'hF);
        wr(12'h104, 32'h0, 4'hF);
        wr(12'h000, 32'h5, 4'h1);
        idle(12);
`ifdef TIMER_ONESHOT_EN
        rd(12'h000, 32'h0000_0104, "oneshot_stopped");
        rd(12'h004, 32'd0, "oneshot_cnt_cleared");
`else
        rd(12'h000, 32'h0000_0101, "freerun_tcr");
        rd(12'h004, 32'd13, "freerun_cnt");
`endif
        rd(12'h010, 32'h1, "ch0_int_st");

        idle(1);
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
